// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Bridges the multicycle control FSM's level-held memory controls
//            to a req/ack memory bus. Issues one bus transaction per control
//            state and performs byte-lane extraction with sign or zero
//            extension on byte loads. Byte stores are done as read-modify-write.
//            A stall is driven back to the FSM while an access is in flight.
// Ports    : clk, nrst            - clock, async active-low reset
//            state_code           - control-FSM state code (change = new state)
//            IorD/MemRead/MemWrite/BorD/byte_sext - access controls
//            pc_addr/alu_addr     - byte address sources
//            wdata                - store data (byte stores use [7:0])
//            mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata - memory bus
//            rdata/rdata_valid    - registered load result and update pulse
//            stall                - access in flight
//            err                  - sticky error (illegal request or timeout)
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [3:0]        state_code,
  input  logic              IorD,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              BorD,
  input  logic              byte_sext,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              stall,
  output logic              err
);

  // Last counter value before the TIMEOUT-th unacknowledged request cycle.
  localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RMW_RD  = 3'd3,
    S_RMW_WR  = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_last, w_last_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic              r_byte, w_byte_nxt;
  logic              r_sext, w_sext_nxt;
  logic              r_lane, w_lane_nxt;
  logic [7:0]        r_wbyte, w_wbyte_nxt;
  logic              w_req_nxt, w_we_nxt, w_valid_nxt, w_err_nxt;
  logic [ADDR_W-2:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt, w_rdata_nxt;

  logic [ADDR_W-1:0] w_addr_sel;
  logic              w_change, w_illegal, w_go, w_timeout;
  logic [7:0]        w_lane_byte;
  logic [DATA_W-1:0] w_merged;

  assign w_addr_sel  = IorD ? alu_addr : pc_addr;
  assign w_change    = (state_code != r_last);
  assign w_illegal   = (MemRead & MemWrite) | (BorD & w_addr_sel[0]);
  assign w_go        = (r_state == S_IDLE) & w_change & (MemRead | MemWrite) & ~w_illegal;
  assign w_lane_byte = mem_rdata[{r_lane, 3'b000} +: 8];
  assign w_timeout   = (r_cnt == c_TIMEOUT_LAST);

  // Stall covers the launch cycle itself so the control FSM holds its state
  // from the first cycle of the access; gated by reset so it is 0 in reset.
  assign stall = nrst & ((r_state != S_IDLE) | w_go);

  always_comb begin
    w_merged = mem_rdata;
    w_merged[{r_lane, 3'b000} +: 8] = r_wbyte;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_byte_nxt  = r_byte;
    w_sext_nxt  = r_sext;
    w_lane_nxt  = r_lane;
    w_wbyte_nxt = r_wbyte;
    w_req_nxt   = mem_req;
    w_we_nxt    = mem_we;
    w_addr_nxt  = mem_addr;
    w_wdata_nxt = mem_wdata;
    w_rdata_nxt = rdata;
    w_valid_nxt = 1'b0;
    w_err_nxt   = err;

    // Shared wait/timeout handling for every state with a request on the bus.
    if ((r_state != S_IDLE) && mem_req && !mem_ack) begin
      if (w_timeout) begin
        w_err_nxt   = 1'b1;
        w_req_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
        w_state_nxt = S_IDLE;
      end else begin
        w_cnt_nxt = r_cnt + 8'd1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (w_change) begin
          w_last_nxt = state_code;
        end
        if (w_change && (MemRead || MemWrite)) begin
          if (w_illegal) begin
            w_err_nxt = 1'b1;
          end else begin
            w_req_nxt   = 1'b1;
            w_cnt_nxt   = 8'd0;
            w_addr_nxt  = w_addr_sel[ADDR_W-1:1];
            w_byte_nxt  = ~BorD;
            w_sext_nxt  = byte_sext;
            w_lane_nxt  = w_addr_sel[0];
            w_wbyte_nxt = wdata[7:0];
            if (MemWrite && BorD) begin
              w_we_nxt    = 1'b1;
              w_wdata_nxt = wdata;
              w_state_nxt = S_WR_WAIT;
            end else if (MemWrite) begin
              w_we_nxt    = 1'b0;
              w_state_nxt = S_RMW_RD;
            end else begin
              w_we_nxt    = 1'b0;
              w_state_nxt = S_RD_WAIT;
            end
          end
        end
      end
      S_RD_WAIT: begin
        if (mem_ack) begin
          w_req_nxt   = 1'b0;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_IDLE;
          w_rdata_nxt = r_byte ? {{(DATA_W-8){r_sext & w_lane_byte[7]}}, w_lane_byte}
                               : mem_rdata;
        end
      end
      S_WR_WAIT: begin
        if (mem_ack) begin
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_RMW_RD: begin
        // Request drops for one cycle while the merged word is staged.
        if (mem_ack) begin
          w_req_nxt   = 1'b0;
          w_wdata_nxt = w_merged;
          w_state_nxt = S_RMW_WR;
        end
      end
      S_RMW_WR: begin
        if (!mem_req) begin
          w_req_nxt = 1'b1;
          w_we_nxt  = 1'b1;
          w_cnt_nxt = 8'd0;
        end else if (mem_ack) begin
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_last      <= 4'hF;
      r_cnt       <= 8'd0;
      r_byte      <= 1'b0;
      r_sext      <= 1'b0;
      r_lane      <= 1'b0;
      r_wbyte     <= 8'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_cnt       <= w_cnt_nxt;
      r_byte      <= w_byte_nxt;
      r_sext      <= w_sext_nxt;
      r_lane      <= w_lane_nxt;
      r_wbyte     <= w_wbyte_nxt;
      mem_req     <= w_req_nxt;
      mem_we      <= w_we_nxt;
      mem_addr    <= w_addr_nxt;
      mem_wdata   <= w_wdata_nxt;
      rdata       <= w_rdata_nxt;
      rdata_valid <= w_valid_nxt;
      err         <= w_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit: directed scenarios with
//            literal expectations plus randomized traffic checked every cycle
//            against a transaction-level model and a bench-side memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic [3:0]  state_code = 4'd0;
  logic        IorD = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, BorD = 1'b0, byte_sext = 1'b0;
  logic [15:0] pc_addr = 16'd0, alu_addr = 16'd0, wdata = 16'd0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata = 16'd0, rdata;
  logic        rdata_valid, stall, err;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nrst(nrst), .state_code(state_code), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .BorD(BorD), .byte_sext(byte_sext),
    .pc_addr(pc_addr), .alu_addr(alu_addr), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rdata(rdata),
    .rdata_valid(rdata_valid), .stall(stall), .err(err)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] mem [0:63];

  // Responder control: 0 random acks, 1 fixed wait count, 2 never ack.
  int ack_mode = 0, ack_waits = 0, wcnt = 0;

  // Behavioural model: what the bus and result outputs must be next cycle.
  bit          m_busy, m_err, m_gap, m_second, m_byte, m_sext, m_lane;
  logic [3:0]  m_last;
  logic [7:0]  m_wb;
  int          m_job, m_wait;  // job: 0 read, 1 word write, 2 byte write
  bit          e_req, e_we, e_valid;
  logic [14:0] e_addr;
  logic [15:0] e_wdata, e_rdata;

  // Observations for the directed scenarios.
  int n_stall, n_req, n_valid, n_rise, n_fall, cyc;
  int rise_cyc [0:3];
  int fall_cyc [0:3];
  bit prev_req;
  logic [15:0] v_rdata, wr_data;
  logic [14:0] wr_addr, first_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] extract(input logic [15:0] d, input bit lane,
                                          input bit sext, input bit is_byte);
    int b;
    if (!is_byte) return d;
    b = int'((d >> (lane * 8)) & 16'h00FF);
    if (sext && b >= 128) b = b - 256;
    return b[15:0];
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] d, input bit lane, input logic [7:0] wb);
    logic [15:0] mask, ins;
    mask = 16'h00FF << (lane * 8);
    ins  = {8'h00, wb} << (lane * 8);
    return (d & ~mask) | ins;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_gap = 0; m_second = 0; m_last = 4'hF;
    e_req = 0; e_we = 0; e_valid = 0; e_addr = '0; e_wdata = '0; e_rdata = '0;
  endtask

  task automatic model_done();
    e_req = 0; e_we = 0; m_busy = 0;
  endtask

  task automatic model_step();
    logic [15:0] sel;
    sel = IorD ? alu_addr : pc_addr;
    e_valid = 1'b0;
    if (!m_busy) begin
      if (state_code != m_last) begin
        m_last = state_code;
        if (MemRead || MemWrite) begin
          if ((MemRead && MemWrite) || (BorD && sel[0])) m_err = 1'b1;
          else begin
            m_busy = 1; e_req = 1; e_addr = sel[15:1]; m_wait = 0; m_gap = 0; m_second = 0;
            m_byte = !BorD; m_sext = byte_sext; m_lane = sel[0]; m_wb = wdata[7:0];
            if (MemWrite && BorD) begin m_job = 1; e_we = 1; e_wdata = wdata; end
            else begin m_job = MemWrite ? 2 : 0; e_we = 0; end
          end
        end
      end
    end else if (m_gap) begin
      m_gap = 0; m_second = 1; e_req = 1; e_we = 1; m_wait = 0;
    end else if (mem_ack) begin
      if (m_job == 0) begin
        e_rdata = extract(mem_rdata, m_lane, m_sext, m_byte); e_valid = 1; model_done();
      end else if (m_job == 2 && !m_second) begin
        e_wdata = merge(mem_rdata, m_lane, m_wb); e_req = 0; m_gap = 1;
      end else model_done();
    end else begin
      m_wait++;
      if (m_wait == TIMEOUT) begin m_err = 1; model_done(); end
    end
  endtask

  task automatic respond();
    mem_rdata = 16'($urandom);
    mem_ack = 1'b0;
    case (ack_mode)
      0: mem_ack = mem_req ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) == 0);
      1: begin
        if (mem_req) begin
          if (wcnt == ack_waits) begin mem_ack = 1'b1; wcnt = 0; end
          else wcnt++;
        end else wcnt = 0;
      end
      default: mem_ack = 1'b0;
    endcase
    if (mem_req && !mem_we) mem_rdata = mem[mem_addr[5:0]];
  endtask

  task automatic clear_obs();
    n_stall = 0; n_req = 0; n_valid = 0; n_rise = 0; n_fall = 0; prev_req = 0;
    v_rdata = 'x; wr_addr = 'x; wr_data = 'x; first_addr = 'x;
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic cycle();
    bit go;
    logic [15:0] sel;
    respond();
    #1;
    sel = IorD ? alu_addr : pc_addr;
    go = !m_busy && (state_code != m_last) && (MemRead || MemWrite) &&
         !((MemRead && MemWrite) || (BorD && sel[0]));
    chk("stall", stall, m_busy || go);
    chk("mem_req", mem_req, e_req);
    chk("mem_we", mem_we, e_we);
    if (e_req) chk("mem_addr", mem_addr, e_addr);
    if (e_req && e_we) chk("mem_wdata", mem_wdata, e_wdata);
    chk("rdata_valid", rdata_valid, e_valid);
    chk("rdata", rdata, e_rdata);
    chk("err", err, m_err);
    n_stall += stall; n_req += mem_req; n_valid += rdata_valid;
    if (rdata_valid) v_rdata = rdata;
    if (mem_req && !prev_req) begin
      if (n_rise < 4) rise_cyc[n_rise] = cyc;
      if (n_rise == 0) first_addr = mem_addr;
      n_rise++;
    end
    if (!mem_req && prev_req) begin
      if (n_fall < 4) fall_cyc[n_fall] = cyc;
      n_fall++;
    end
    prev_req = mem_req;
    if (mem_req && mem_we && mem_ack) begin
      mem[mem_addr[5:0]] = mem_wdata; wr_addr = mem_addr; wr_data = mem_wdata;
    end
    model_step();
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    mem_ack = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    model_reset();
    @(posedge clk); #1;
    nrst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    cyc = 0;
    clear_obs();
    @(posedge clk); #1;
    do_reset();

    // Fetch with two wait states.
    ack_mode = 1; ack_waits = 2;
    state_code = 4'd0; MemRead = 0; cycle();
    mem[8] = 16'hA5C3; pc_addr = 16'h0010; IorD = 0; BorD = 1; MemRead = 1; state_code = 4'd1;
    clear_obs(); run(6);
    chk("fetch_addr", first_addr, 15'h0008);
    chk("fetch_rdata", v_rdata, 16'hA5C3);
    chk("fetch_valid_pulses", n_valid, 1);
    chk("fetch_stall_cycles", n_stall, 4);
    chk("fetch_req_cycles", n_req, 3);

    // LB then LBU from the upper lane.
    ack_waits = 0;
    mem[16] = 16'h80FF; IorD = 1; alu_addr = 16'h0021; BorD = 0; byte_sext = 1; state_code = 4'd2;
    clear_obs(); run(4);
    chk("lb_rdata", v_rdata, 16'hFF80);
    chk("lb_valid_pulses", n_valid, 1);
    byte_sext = 0; state_code = 4'd3;
    clear_obs(); run(4);
    chk("lbu_rdata", v_rdata, 16'h0080);

    // SB: read-modify-write with one idle cycle between request phases.
    mem[24] = 16'hAAAA; MemRead = 0; MemWrite = 1; alu_addr = 16'h0030; wdata = 16'h1234;
    state_code = 4'd4;
    clear_obs(); run(6);
    chk("sb_mem_word", mem[24], 16'hAA34);
    chk("sb_wr_addr", wr_addr, 15'h0018);
    chk("sb_wr_data", wr_data, 16'hAA34);
    chk("sb_req_phases", n_rise, 2);
    chk("sb_gap_cycles", rise_cyc[1] - fall_cyc[0], 1);

    // Repeat suppression within one control state.
    MemWrite = 0; MemRead = 1; IorD = 0; BorD = 1; pc_addr = 16'h0004; ack_waits = 1;
    state_code = 4'd7;
    clear_obs(); run(10);
    chk("repeat_one_access", n_rise, 1);
    state_code = 4'd8; run(6);
    chk("repeat_new_state", n_rise, 2);

    // Misaligned word access.
    IorD = 1; alu_addr = 16'h0005; state_code = 4'd9;
    clear_obs(); run(3);
    chk("misalign_err", err, 1);
    chk("misalign_no_req", n_req, 0);
    chk("misalign_no_stall", n_stall, 0);
    MemRead = 0;
    do_reset();

    // Timeout: no ack at all.
    ack_mode = 2; IorD = 0; pc_addr = 16'h0002; BorD = 1; MemRead = 1; state_code = 4'd1;
    clear_obs(); run(TIMEOUT + 4);
    chk("timeout_req_cycles", n_req, TIMEOUT);
    chk("timeout_err", err, 1);
    chk("timeout_req_low", mem_req, 0);
    chk("timeout_stall_low", stall, 0);
    chk("timeout_no_valid", n_valid, 0);
    MemRead = 0;
    do_reset();

    // Reset during the write half of a read-modify-write.
    ack_mode = 1; ack_waits = 0; mem[24] = 16'h1111;
    MemWrite = 1; BorD = 0; IorD = 1; alu_addr = 16'h0030; wdata = 16'h5678; state_code = 4'd5;
    run(3);
    chk("rmw_wr_req_high", mem_req, 1);
    chk("rmw_wr_we_high", mem_we, 1);
    do_reset();
    chk("rmw_no_write", mem[24], 16'h1111);
    MemWrite = 0; MemRead = 1; BorD = 1; IorD = 0; pc_addr = 16'h0030; state_code = 4'd6;
    clear_obs(); run(4);
    chk("post_reset_rdata", v_rdata, 16'h1111);

    // Randomized traffic against the model.
    ack_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      int op;
      if (i % 150 == 0) do_reset();
      if ($urandom_range(0, 9) < 3) state_code = 4'($urandom);
      op = $urandom_range(0, 19);
      MemRead   = (op < 8) || (op == 19);
      MemWrite  = (op >= 8 && op < 16) || (op == 19);
      BorD      = 1'($urandom_range(0, 1));
      byte_sext = 1'($urandom_range(0, 1));
      IorD      = 1'($urandom_range(0, 1));
      pc_addr   = 16'($urandom_range(0, 63) * 2);
      alu_addr  = 16'($urandom_range(0, 127));
      if (BorD && ($urandom_range(0, 3) != 0)) alu_addr[0] = 1'b0;
      wdata     = 16'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly downstream of the multicycle control FSM, between the datapath and the unified instruction/data memory.
- Turns the FSM's level-held controls (IorD, MemRead, MemWrite, BorD, LB/LBU select) into one bus transaction per control state, using a req/ack memory handshake with wait states.
- Performs byte-lane extraction with sign or zero extension on byte loads, and read-modify-write on byte stores.
- Drives a stall back to the FSM while an access is in flight.

Parameters:
- DATA_W, 16, datapath and memory word width in bits; must be even.
- ADDR_W, 16, byte address width.
- TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting; 8-bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- state_code  in  4  current control-FSM state code (STATEC); a change marks a new control state.
- IorD  in  1  0 = use pc_addr, 1 = use alu_addr.
- MemRead  in  1  read request level.
- MemWrite  in  1  write request level.
- BorD  in  1  1 = word access, 0 = byte access.
- byte_sext  in  1  1 = sign-extend byte load (LB), 0 = zero-extend (LBU).
- pc_addr  in  ADDR_W  program counter byte address.
- alu_addr  in  ADDR_W  ALUOut byte address.
- wdata  in  DATA_W  store data from the B register; byte stores use bits [7:0].
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable.
- mem_addr  out  ADDR_W-1  word address (selected byte address >> 1).
- mem_wdata  out  DATA_W  bus write data.
- mem_ack  in  1  bus completion; read data is valid in the same cycle.
- mem_rdata  in  DATA_W  bus read data.
- rdata  out  DATA_W  registered load/fetch result for the IR/MDR.
- rdata_valid  out  1  one-cycle pulse when rdata is updated.
- stall  out  1  high while an access is in flight.
- err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; mem_req, mem_we, rdata_valid, stall, err=0; rdata, mem_wdata, mem_addr=0; last_state=4'hF; timeout counter=0.
- Launch condition: in IDLE, an access launches when state_code != last_state AND (MemRead|MemWrite). last_state <= state_code on every launch and on every IDLE cycle where state_code changes. An access is therefore never repeated within one control state.
- Address: addr = IorD ? alu_addr : pc_addr. Byte lane: addr[0]=0 selects [7:0], addr[0]=1 selects [15:8].
- Illegal requests set err, perform no bus cycle and stay in IDLE:
  - MemRead & MemWrite both high at launch.
  - Word access (BorD=1) with addr[0]=1.
- States and transitions:
  - IDLE: on launch, register the address, data and controls; set stall=1, mem_req=1. Word read or byte read -> RD_WAIT. Word write -> WR_WAIT with mem_we=1, mem_wdata=wdata. Byte write -> RMW_RD with mem_we=0.
  - RD_WAIT: on mem_ack, drop mem_req and capture rdata, then go to IDLE; rdata_valid pulses in the next cycle (first cycle back in IDLE). Word read: rdata = mem_rdata. Byte read: rdata = selected byte, extended per byte_sext.
  - WR_WAIT: on mem_ack, drop mem_req/mem_we and go to IDLE. No rdata_valid.
  - RMW_RD: on mem_ack, merge wdata[7:0] into the selected lane of mem_rdata, load mem_wdata, drop mem_req for exactly one cycle -> RMW_WR.
  - RMW_WR: assert mem_req=1, mem_we=1; on mem_ack, drop both -> IDLE.
- stall clears in the cycle the FSM returns to IDLE.
- Latency with zero-wait memory (ack in the first req cycle): read 2 cycles launch->rdata_valid; word write 1 cycle; byte write 3 cycles.
- Timeout: the counter increments each cycle mem_req=1 without mem_ack and resets to 0 on a new request. When it reaches TIMEOUT: set err, deassert mem_req/mem_we, go to IDLE, no rdata_valid.
- mem_ack while in IDLE is ignored.
- Control inputs are sampled only at launch; later changes during the access are ignored.

Test Plan:
- Fetch: state_code 0->1, MemRead=1, IorD=0, pc_addr=0x0010, ack after 2 waits with mem_rdata=0xA5C3 -> mem_addr=0x0008, rdata=0xA5C3, rdata_valid 1 pulse, stall high for 4 cycles.
- LB/LBU: alu_addr=0x0021, mem_rdata=0x80FF; byte_sext=1 -> rdata=0xFF80; byte_sext=0 -> rdata=0x0080.
- SB: alu_addr=0x0030, wdata=0x1234, read returns 0xAAAA -> a second bus cycle writes mem_wdata=0xAA34 to word 0x0018 with mem_we=1; there is exactly one idle cycle between the two req phases.
- Repeat suppression: state_code held at 7 with MemRead high for 10 cycles -> exactly one mem_req pulse; changing state_code to 8 -> a second access.
- Errors: word access at alu_addr=0x0005 -> err=1, no mem_req. No ack for TIMEOUT cycles -> err=1, mem_req drops, stall drops.
- Reset mid-RMW: nrst low during RMW_WR -> all outputs at reset values immediately, no write completes; after release, a new launch works normally.
